alu_issue_stage: RTL and testbench

Issue stage in front of the execute-stage ALU. It accepts decoded instruction fields and register operands over a valid/ready handshake and translates ALUOp, funct3 and funct7[5] into the 4-bit ALU operation code. It selects SrcB (rs2 or immediate) and presents SrcA, SrcB and Operation to the ALU from a 2-entry in-order skid buffer. It generates the operation codes the ALU consumes and decouples decode from execute back-pressure.

---
 rtl/alu_issue_stage.sv | 232 +++++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// Issue stage ahead of the execute ALU. Decodes ALUOp/funct3/funct7[5]
// into the 4-bit ALU operation, selects SrcB, and holds up to two issued
// entries in an in-order skid buffer so that decode is decoupled from
// execute back-pressure.
//
// Handshake contract (both sides): a transfer happens on a rising clock
// edge where valid && ready are both high. Valid, once raised by this
// stage, stays high with stable data until the transfer completes, unless
// flush or reset is asserted. in_ready depends only on registered
// occupancy, so there is no combinational path from out_ready to in_ready.
//
// Buffer organisation: slot r_head always drives the outputs. r_tail holds
// the second entry when the buffer is full. When the buffer drains, r_head
// is left untouched, so the data outputs keep their last values.

module alu_issue_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  // decode side
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_alu_op,
  input  logic [2:0]               in_funct3,
  input  logic                     in_funct7b5,
  input  logic                     in_alu_src,
  input  logic [DATA_WIDTH-1:0]    in_rs1,
  input  logic [DATA_WIDTH-1:0]    in_rs2,
  input  logic [DATA_WIDTH-1:0]    in_imm,
  input  logic [4:0]               in_rd,
  // execute side
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_src_a,
  output logic [DATA_WIDTH-1:0]    out_src_b,
  output logic [OPCODE_LENGTH-1:0] out_operation,
  output logic                     out_illegal,
  output logic [4:0]               out_rd,
  // debug: buffer occupancy state (0, 1 or 2 entries)
  output logic [1:0]               dbg_count
);

  // ALU operation encodings
  localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b0011);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0110);
  localparam logic [OPCODE_LENGTH-1:0] OP_ILL = OPCODE_LENGTH'(4'b0111);
  localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLT = OPCODE_LENGTH'(4'b1100);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b1101);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(4'b1110);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(4'b1111);

  // ALUOp encodings from the main decoder
  localparam logic [1:0] ALUOP_MEM  = 2'b00;
  localparam logic [1:0] ALUOP_BR   = 2'b01;
  localparam logic [1:0] ALUOP_RTYP = 2'b10;
  localparam logic [1:0] ALUOP_ITYP = 2'b11;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    src_a;
    logic [DATA_WIDTH-1:0]    src_b;
    logic [OPCODE_LENGTH-1:0] operation;
    logic                     illegal;
    logic [4:0]               rd;
  } entry_t;

  // Buffer occupancy doubles as the control state
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } occ_t;

  occ_t   r_occ;
  occ_t   w_occ_next;
  entry_t r_head;
  entry_t r_tail;
  entry_t w_head_next;
  entry_t w_tail_next;
  entry_t w_new;

  logic                     w_push;
  logic                     w_pop;
  logic [OPCODE_LENGTH-1:0] w_op;
  logic                     w_illegal;
  logic [OPCODE_LENGTH-1:0] w_arith_op;
  logic                     w_arith_bad;

  // Shared R-type/I-type funct3 mapping; funct7b5 selects SUB/SRA variants
  always_comb begin
    w_arith_op  = OP_ADD;
    w_arith_bad = 1'b0;
    case (in_funct3)
      3'b000:  w_arith_op = (in_funct7b5 && (in_alu_op == ALUOP_RTYP)) ? OP_SUB : OP_ADD;
      3'b001:  w_arith_op = OP_SLL;
      3'b010:  w_arith_op = OP_SLT;
      3'b011:  w_arith_bad = 1'b1;
      3'b100:  w_arith_op = OP_XOR;
      3'b101:  w_arith_op = in_funct7b5 ? OP_SRA : OP_SRL;
      3'b110:  w_arith_op = OP_OR;
      3'b111:  w_arith_op = OP_AND;
      default: w_arith_bad = 1'b1;
    endcase
  end

  // Full operation decode including the ALUOp-specific legality rules
  always_comb begin
    w_op      = OP_ADD;
    w_illegal = 1'b0;
    case (in_alu_op)
      ALUOP_MEM: begin
        w_op = OP_ADD;
      end
      ALUOP_BR: begin
        if (in_funct3 == 3'b000 || in_funct3 == 3'b001) begin
          w_op = OP_EQ;
        end else begin
          w_illegal = 1'b1;
        end
      end
      ALUOP_RTYP: begin
        w_op = w_arith_op;
        // funct7b5 only qualifies ADD/SUB and SRL/SRA for register forms
        if (w_arith_bad ||
            (in_funct7b5 && in_funct3 != 3'b000 && in_funct3 != 3'b101)) begin
          w_illegal = 1'b1;
        end
      end
      ALUOP_ITYP: begin
        w_op = w_arith_op;
        // SLLI must carry funct7b5=0; other immediate forms ignore it
        if (w_arith_bad || (in_funct3 == 3'b001 && in_funct7b5)) begin
          w_illegal = 1'b1;
        end
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
    // Illegal entries carry the ALU's zero-result code
    if (w_illegal) begin
      w_op = OP_ILL;
    end
  end

  // Entry captured on a push
  always_comb begin
    w_new.src_a     = in_rs1;
    w_new.src_b     = in_alu_src ? in_imm : in_rs2;
    w_new.operation = w_op;
    w_new.illegal   = w_illegal;
    w_new.rd        = in_rd;
  end

  assign in_ready  = (r_occ != S_FULL);
  assign out_valid = (r_occ != S_EMPTY);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // Next-state and next-slot logic; flush wins over push and pop
  always_comb begin
    w_occ_next  = r_occ;
    w_head_next = r_head;
    w_tail_next = r_tail;
    if (flush) begin
      w_occ_next = S_EMPTY;
    end else begin
      case (r_occ)
        S_EMPTY: begin
          if (w_push) begin
            w_head_next = w_new;
            w_occ_next  = S_ONE;
          end
        end
        S_ONE: begin
          case ({w_push, w_pop})
            2'b10: begin
              w_tail_next = w_new;
              w_occ_next  = S_FULL;
            end
            2'b01: begin
              w_occ_next = S_EMPTY;
            end
            2'b11: begin
              w_head_next = w_new;
            end
            default: begin
              w_occ_next = S_ONE;
            end
          endcase
        end
        S_FULL: begin
          if (w_pop) begin
            w_head_next = r_tail;
            w_occ_next  = S_ONE;
          end
        end
        default: begin
          w_occ_next = S_EMPTY;
        end
      endcase
    end
  end

  // State and buffer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_occ  <= S_EMPTY;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_occ  <= w_occ_next;
      r_head <= w_head_next;
      r_tail <= w_tail_next;
    end
  end

  assign out_src_a     = r_head.src_a;
  assign out_src_b     = r_head.src_b;
  assign out_operation = r_head.operation;
  assign out_illegal   = r_head.illegal;
  assign out_rd        = r_head.rd;
  assign dbg_count     = r_occ;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: directed stimulus, a queue-based reference
// model checked on every cycle, and literal spot checks.

module tb_alu_issue_stage;

  localparam int DW = 32;
  localparam int OW = 4;

  typedef struct packed {
    logic [DW-1:0] src_a;
    logic [DW-1:0] src_b;
    logic [OW-1:0] op;
    logic          ill;
    logic [4:0]    rd;
  } ent_t;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_alu_op;
  logic [2:0]    in_funct3;
  logic          in_funct7b5;
  logic          in_alu_src;
  logic [DW-1:0] in_rs1;
  logic [DW-1:0] in_rs2;
  logic [DW-1:0] in_imm;
  logic [4:0]    in_rd;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_src_a;
  logic [DW-1:0] out_src_b;
  logic [OW-1:0] out_operation;
  logic          out_illegal;
  logic [4:0]    out_rd;
  logic [1:0]    dbg_count;

  int checks = 0;
  int errors = 0;

  ent_t       exp_q[$];
  ent_t       shown;
  logic [4:0] issued_q[$];

  alu_issue_stage #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_op(in_alu_op), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_alu_src(in_alu_src), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_src_a(out_src_a), .out_src_b(out_src_b),
    .out_operation(out_operation), .out_illegal(out_illegal),
    .out_rd(out_rd), .dbg_count(dbg_count)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Decode written from the instruction-class rules, not as a mux tree.
  function automatic logic [4:0] ref_decode(input logic [1:0] aop, input logic [2:0] f3,
                                            input logic f7);
    logic [3:0] op;
    logic       ill;
    logic       is_r;
    is_r = (aop == 2'b10);
    ill  = 1'b0;
    op   = 4'b0010;
    if (aop == 2'b01) begin
      if (f3 > 3'd1) ill = 1'b1;
      else op = 4'b1000;
    end else if (aop[1]) begin
      if (f3 == 3'd0) op = (is_r && f7) ? 4'b0110 : 4'b0010;
      else if (f3 == 3'd1) op = 4'b1101;
      else if (f3 == 3'd2) op = 4'b1100;
      else if (f3 == 3'd3) ill = 1'b1;
      else if (f3 == 3'd4) op = 4'b0011;
      else if (f3 == 3'd5) op = f7 ? 4'b1111 : 4'b1110;
      else if (f3 == 3'd6) op = 4'b0001;
      else op = 4'b0000;
      if (is_r && f7 && !(f3 == 3'd0 || f3 == 3'd5)) ill = 1'b1;
      if (!is_r && f3 == 3'd1 && f7) ill = 1'b1;
    end
    if (ill) op = 4'b0111;
    return {op, ill};
  endfunction

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    case (op)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b1111: return $unsigned($signed(a) >>> b[4:0]);
      4'b1110: return a >> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    ent_t       e;
    logic [4:0] d;
    logic       m_push;
    logic       m_pop;
    if (reset) begin
      exp_q.delete();
      shown = '0;
    end else begin
      m_push = in_valid && (exp_q.size() < 2) && !flush;
      m_pop  = (exp_q.size() > 0) && out_ready && !flush;
      d = ref_decode(in_alu_op, in_funct3, in_funct7b5);
      e.src_a = in_rs1;
      e.src_b = in_alu_src ? in_imm : in_rs2;
      e.op    = d[4:1];
      e.ill   = d[0];
      e.rd    = in_rd;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (m_pop) void'(exp_q.pop_front());
        if (m_push) exp_q.push_back(e);
      end
      if (exp_q.size() > 0) shown = exp_q[0];
    end
  end

  // Log of destination tags actually issued by the DUT
  always @(posedge clk) begin
    if (!reset && !flush && out_valid && out_ready) issued_q.push_back(out_rd);
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    ent_t e;
    e = (exp_q.size() > 0) ? exp_q[0] : shown;
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(exp_q.size() != 2));
    chk("count", 32'(dbg_count), 32'(exp_q.size()));
    chk("src_a", out_src_a, e.src_a);
    chk("src_b", out_src_b, e.src_b);
    chk("operation", 32'(out_operation), 32'(e.op));
    chk("illegal", 32'(out_illegal), 32'(e.ill));
    chk("rd", 32'(out_rd), 32'(e.rd));
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [1:0] aop, input logic [2:0] f3, input logic f7,
                       input logic src, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [4:0] rd);
    in_valid    = 1'b1;
    in_alu_op   = aop;
    in_funct3   = f3;
    in_funct7b5 = f7;
    in_alu_src  = src;
    in_rs1      = rs1;
    in_rs2      = rs2;
    in_imm      = imm;
    in_rd       = rd;
  endtask

  task automatic wait_accept();
    logic ok;
    logic done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) done = 1'b1;
    end
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic push(input logic [1:0] aop, input logic [2:0] f3, input logic f7,
                      input logic src, input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [31:0] imm, input logic [4:0] rd);
    drive(aop, f3, f7, src, rs1, rs2, imm, rd);
    wait_accept();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_alu_op = '0; in_funct3 = '0; in_funct7b5 = 1'b0; in_alu_src = 1'b0;
    in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_rd = '0;
    idle(2);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_src_a", out_src_a, 32'd0);
    chk("rst_src_b", out_src_b, 32'd0);
    chk("rst_operation", 32'(out_operation), 32'd0);
    chk("rst_rd", 32'(out_rd), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // R-type SUB: 10 - 3
    push(2'b10, 3'b000, 1'b1, 1'b0, 32'd10, 32'd3, 32'hDEAD, 5'd1);
    chk("sub_valid", 32'(out_valid), 32'd1);
    chk("sub_op", 32'(out_operation), 32'b0110);
    chk("sub_src_a", out_src_a, 32'd10);
    chk("sub_src_b", out_src_b, 32'd3);
    chk("sub_illegal", 32'(out_illegal), 32'd0);
    chk("sub_result", alu_ref(out_src_a, out_src_b, out_operation), 32'd7);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;

    // I-type SRAI by 4 on 0x80000000
    push(2'b11, 3'b101, 1'b1, 1'b1, 32'h8000_0000, 32'h1234, 32'h404, 5'd2);
    chk("srai_op", 32'(out_operation), 32'b1111);
    chk("srai_src_b", out_src_b, 32'h404);
    chk("srai_result", alu_ref(out_src_a, out_src_b, out_operation), 32'hF800_0000);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    push(2'b11, 3'b011, 1'b0, 1'b1, 32'd5, 32'd6, 32'd7, 5'd3);
    chk("ill_op", 32'(out_operation), 32'b0111);
    chk("ill_flag", 32'(out_illegal), 32'd1);
    out_ready = 1'b1;
    idle(2);
    chk("drained_valid", 32'(out_valid), 32'd0);
    chk("hold_rd", 32'(out_rd), 32'd3);

    // Full decode table streamed at full rate
    for (int a = 0; a < 4; a++)
      for (int f = 0; f < 8; f++)
        for (int s = 0; s < 2; s++)
          push(2'(a), 3'(f), 1'(s), 1'((a + f) & 1), 32'(a * 1000 + f * 10 + s),
               32'(f * 7 + 1), 32'hFFFF_FF00 | 32'(f), 5'((a * 16 + f * 2 + s) & 31));
    idle(3);

    // Back-pressure: three pushes with out_ready low
    out_ready = 1'b0;
    base = issued_q.size();
    push(2'b00, 3'b010, 1'b0, 1'b1, 32'd100, 32'd0, 32'd4, 5'd21);
    push(2'b10, 3'b111, 1'b0, 1'b0, 32'hF0F0, 32'h0FF0, 32'd0, 5'd22);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    drive(2'b10, 3'b100, 1'b0, 1'b0, 32'h55, 32'hAA, 32'd0, 5'd23);
    idle(3);
    chk("held_in_ready", 32'(in_ready), 32'd0);
    chk("held_rd", 32'(out_rd), 32'd21);
    chk("held_count", 32'(dbg_count), 32'd2);
    out_ready = 1'b1;
    wait_accept();
    idle(4);
    chk("bp_issued_n", 32'(issued_q.size() - base), 32'd3);
    if (issued_q.size() - base == 3) begin
      chk("bp_order0", 32'(issued_q[base]), 32'd21);
      chk("bp_order1", 32'(issued_q[base + 1]), 32'd22);
      chk("bp_order2", 32'(issued_q[base + 2]), 32'd23);
    end

    // Simultaneous push/pop at count=1 over 10 entries, no gaps
    base = issued_q.size();
    for (int i = 0; i < 10; i++) begin
      push(2'b10, 3'(i % 8), 1'b0, 1'b0, 32'(i), 32'(i + 100), 32'd0, 5'(10 + i));
      drive(2'b10, 3'((i + 1) % 8), 1'b0, 1'b0, 32'(i + 1), 32'(i + 101), 32'd0, 5'(11 + i));
      in_valid = 1'b0;
      chk("stream_count", 32'(dbg_count), 32'd1);
    end
    idle(2);
    chk("stream_issued_n", 32'(issued_q.size() - base), 32'd10);
    for (int i = 0; i < 10; i++)
      if (base + i < issued_q.size()) chk("stream_order", 32'(issued_q[base + i]), 32'(10 + i));

    // Flush with the buffer full and an entry presented
    out_ready = 1'b0;
    base = issued_q.size();
    push(2'b10, 3'b000, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0, 5'd1);
    push(2'b10, 3'b000, 1'b0, 1'b0, 32'd3, 32'd4, 32'd0, 5'd2);
    drive(2'b11, 3'b000, 1'b0, 1'b1, 32'd9, 32'd0, 32'd9, 5'd31);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    // Flush at count=1 with in_ready high: the presented entry is dropped
    push(2'b00, 3'b000, 1'b0, 1'b0, 32'd5, 32'd5, 32'd0, 5'd5);
    drive(2'b11, 3'b000, 1'b0, 1'b1, 32'd8, 32'd0, 32'd8, 5'd30);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush1_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    idle(4);
    chk("flush_nothing_issued", 32'(issued_q.size() - base), 32'd0);

    // Reset asserted mid-transfer
    out_ready = 1'b0;
    push(2'b10, 3'b110, 1'b0, 1'b0, 32'h11, 32'h22, 32'd0, 5'd7);
    push(2'b10, 3'b110, 1'b0, 1'b0, 32'h33, 32'h44, 32'd0, 5'd8);
    base = issued_q.size();
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_src_a", out_src_a, 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    idle(4);
    chk("arst_nothing_issued", 32'(issued_q.size() - base), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
